// File: rtl/ov7670_pixel_source.sv
// OV7670 sensor emulator: drives PCLK/VSYNC/HREF/D[7:0] with RGB565 test patterns.
// Ports: clk, rst_n, enable, pattern_sel[1:0] in; cam_pclk, cam_vsync, cam_href,
// cam_data[7:0], frame_start, frame_done, frame_count[15:0], busy out.
// Optional macro OV_SRC_CKSUM_EN adds frame_cksum[15:0] (byte sum of each frame).
module ov7670_pixel_source #(
    parameter int PCLK_HALF = 2,
    parameter int H_ACTIVE  = 320,
    parameter int H_BLANK   = 144,
    parameter int V_ACTIVE  = 240,
    parameter int VS_LINES  = 3,
    parameter int V_BP      = 17,
    parameter int V_FP      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic [15:0] frame_count,
`ifdef OV_SRC_CKSUM_EN
    output logic [15:0] frame_cksum,
`endif
    output logic        busy
);

    localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_LINES = VS_LINES + V_BP + V_ACTIVE + V_FP;
    localparam int HW          = $clog2(LINE_LEN + 1);
    localparam int VW          = $clog2(FRAME_LINES + 1);
    localparam int DW          = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;
    localparam int BAR_W       = H_ACTIVE / 8;

    localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_ACT2 = HW'(2 * H_ACTIVE);
    localparam logic [VW-1:0] V_LAST = VW'(FRAME_LINES - 1);
    localparam logic [VW-1:0] V_VS   = VW'(VS_LINES);
    localparam logic [VW-1:0] V_A0   = VW'(VS_LINES + V_BP);
    localparam logic [VW-1:0] V_A1   = VW'(VS_LINES + V_BP + V_ACTIVE);
    localparam logic [DW-1:0] D_LAST = DW'(PCLK_HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;
    logic [1:0]    pat, pat_nxt;
    logic          load, fall, wrap, h_end, v_end;

    logic [15:0] px_x, px_y, pix;
    logic [2:0]  bar;
    logic        vs_nxt, href_nxt;
    logic [7:0]  byte_nxt;

    assign busy  = (state != IDLE);
    // A falling pclk edge is the only point where the position advances
    assign fall  = busy && cam_pclk && (div_cnt == D_LAST);
    assign h_end = (h_cnt == H_LAST);
    assign v_end = (v_cnt == V_LAST);
    assign wrap  = fall && h_end && v_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    if (enable) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (!enable) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (wrap) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        h_nxt   = h_cnt;
        v_nxt   = v_cnt;
        pat_nxt = pat;
        if (load) begin
            h_nxt   = '0;
            v_nxt   = '0;
            pat_nxt = pattern_sel;
        end else if (fall) begin
            if (h_end) begin
                h_nxt = '0;
                v_nxt = v_end ? '0 : v_cnt + VW'(1);
            end else begin
                h_nxt = h_cnt + HW'(1);
            end
        end
    end

    // Output byte for the position that becomes current after this edge
    always_comb begin
        px_x = 16'(h_nxt >> 1);
        px_y = 16'(v_nxt) - 16'(VS_LINES + V_BP);
        bar  = 3'(px_x / 16'(BAR_W));
        unique case (pat_nxt)
            2'd0: pix = 16'hF800;
            2'd1: begin
                unique case (bar)
                    3'd0:    pix = 16'hFFFF;
                    3'd1:    pix = 16'hFFE0;
                    3'd2:    pix = 16'h07FF;
                    3'd3:    pix = 16'h07E0;
                    3'd4:    pix = 16'hF81F;
                    3'd5:    pix = 16'hF800;
                    3'd6:    pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            end
            2'd2:    pix = px_x + px_y;
            default: pix = ((px_x[3] ^ px_y[3]) == 1'b1) ? 16'hFFFF : 16'h0000;
        endcase
        vs_nxt   = (v_nxt < V_VS);
        href_nxt = (v_nxt >= V_A0) && (v_nxt < V_A1) && (h_nxt < H_ACT2);
        byte_nxt = 8'h00;
        if (href_nxt) begin
            byte_nxt = h_nxt[0] ? pix[7:0] : pix[15:8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            cam_pclk    <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            pat         <= 2'd0;
            cam_vsync   <= 1'b0;
            cam_href    <= 1'b0;
            cam_data    <= 8'h00;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            frame_start <= load;
            frame_done  <= wrap;
            if (wrap) begin
                frame_count <= frame_count + 16'd1;
            end
            if (state_nxt == IDLE) begin
                div_cnt   <= '0;
                cam_pclk  <= 1'b0;
                h_cnt     <= '0;
                v_cnt     <= '0;
                cam_vsync <= 1'b0;
                cam_href  <= 1'b0;
                cam_data  <= 8'h00;
            end else begin
                // New frame restarts pclk low so the first rise is a full half-period away
                if (load) begin
                    div_cnt  <= '0;
                    cam_pclk <= 1'b0;
                end else if (div_cnt == D_LAST) begin
                    div_cnt  <= '0;
                    cam_pclk <= ~cam_pclk;
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
                h_cnt <= h_nxt;
                v_cnt <= v_nxt;
                pat   <= pat_nxt;
                if (load || fall) begin
                    cam_vsync <= vs_nxt;
                    cam_href  <= href_nxt;
                    cam_data  <= byte_nxt;
                end
            end
        end
    end

`ifdef OV_SRC_CKSUM_EN
    logic [15:0] cksum_acc;

    // cam_data is zero outside HREF, so summing every emitted byte is enough
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_acc   <= 16'd0;
            frame_cksum <= 16'd0;
        end else begin
            if (wrap) begin
                frame_cksum <= cksum_acc;
            end
            if (state_nxt == IDLE) begin
                cksum_acc <= 16'd0;
            end else if (load) begin
                cksum_acc <= 16'(byte_nxt);
            end else if (fall) begin
                cksum_acc <= cksum_acc + 16'(byte_nxt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ov7670_pixel_source.sv
// Bench for ov7670_pixel_source: scoreboard of expected pixel bytes
// popped on every cam_pclk rise with HREF high, plus frame timing checks.
module tb_ov7670_pixel_source;

    localparam int PH  = 2;
    localparam int HA  = 8;
    localparam int HB  = 4;
    localparam int VA  = 4;
    localparam int VS  = 1;
    localparam int VBP = 1;
    localparam int VFP = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        cam_pclk, cam_vsync, cam_href;
    logic [7:0]  cam_data;
    logic        frame_start, frame_done, busy;
    logic [15:0] frame_count;
`ifdef OV_SRC_CKSUM_EN
    logic [15:0] frame_cksum;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] cks_q[$];
    bit          sb_on = 1'b0;
    int          href_pulses = 0;
    int          line_bytes = 0;
    logic        prev_pclk = 1'b0;
    logic        prev_href = 1'b0;
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    ov7670_pixel_source #(
        .PCLK_HALF(PH), .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .VS_LINES(VS), .V_BP(VBP), .V_FP(VFP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .pattern_sel(pattern_sel),
        .cam_pclk(cam_pclk),
        .cam_vsync(cam_vsync),
        .cam_href(cam_href),
        .cam_data(cam_data),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .frame_count(frame_count),
`ifdef OV_SRC_CKSUM_EN
        .frame_cksum(frame_cksum),
`endif
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_pix(input logic [1:0] p,
                                            input int x, input int y);
        case (p)
            2'd0: return 16'hF800;
            2'd1: begin
                case (x / (HA / 8))
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2'd2: return 16'(x + y);
            default: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic push_frame(input logic [1:0] p);
        logic [15:0] s;
        logic [15:0] px;
        s = 16'd0;
        for (int y = 0; y < VA; y++) begin
            for (int x = 0; x < HA; x++) begin
                px = exp_pix(p, x, y);
                exp_q.push_back(px[15:8]);
                exp_q.push_back(px[7:0]);
                s = s + {8'h00, px[15:8]} + {8'h00, px[7:0]};
            end
        end
        cks_q.push_back(s);
    endtask

    task automatic wait_pulse(input string tag, input bit want_done,
                              input int budget, output int el);
        el = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (want_done ? frame_done : frame_start) begin
                el = i;
                break;
            end
        end
        check({tag, "_seen"}, 32'(el > 0), 32'd1);
    endtask

    task automatic frame_end(input int cnt);
        logic [31:0] e;
        check("frame_count", frame_count, cnt);
`ifdef OV_SRC_CKSUM_EN
        if (cks_q.size() > 0) e = {16'h0, cks_q.pop_front()};
        else e = 32'h10000;
        check("cksum", frame_cksum, e);
`else
        e = 32'd0;
`endif
    endtask

    task automatic check_quiet(input string p);
        check({p, "_pclk"}, cam_pclk, 0);
        check({p, "_vsync"}, cam_vsync, 0);
        check({p, "_href"}, cam_href, 0);
        check({p, "_data"}, cam_data, 0);
        check({p, "_fs"}, frame_start, 0);
        check({p, "_fd"}, frame_done, 0);
        check({p, "_busy"}, busy, 0);
        check({p, "_count"}, frame_count, 0);
    endtask

    always @(negedge clk) begin
        if (cam_pclk && !prev_pclk && cam_href && sb_on) begin
            if (exp_q.size() > 0) mon_exp = {24'h0, exp_q.pop_front()};
            else mon_exp = 32'h100;
            check("byte", {24'h0, cam_data}, mon_exp);
            line_bytes++;
        end
        if (prev_href && !cam_href && sb_on && rst_n) begin
            check("href_len", line_bytes, 2 * HA);
            href_pulses++;
            line_bytes = 0;
        end
        if (!sb_on) line_bytes = 0;
        prev_pclk = cam_pclk;
        prev_href = cam_href;
    end

    initial begin
        int   el, e1, hp0, pr;
        bit   saw_fd, saw_fs, saw_pclk, saw_busy;
        logic pv;

        repeat (3) @(negedge clk);
        check_quiet("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("idle");

        // Frame 1: solid red; pattern_sel moves to checker mid-frame
        push_frame(2'd0);
        sb_on  = 1'b1;
        enable = 1'b1;
        wait_pulse("f1_start", 1'b0, 10, el);
        #1;
        check("f1_start_lat", el, 1);
        check("f1_vsync", cam_vsync, 1);
        check("f1_busy", busy, 1);
        check("f1_pclk0", cam_pclk, 0);
        pattern_sel = 2'd3;
        push_frame(2'd3);
        hp0 = href_pulses;
        e1 = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (cam_pclk) begin
                e1 = i;
                break;
            end
        end
        check("pclk_rise", e1, PH);
        wait_pulse("f1_done", 1'b1, 600, el);
        #1;
        check("f1_len", e1 + el, 560);
        check("f1_hrefs", href_pulses - hp0, 4);
        frame_end(1);
        check("f2_start", frame_start, 1);

        // Frame 2 checker (sampled at its start); queue bars for frame 3
        pattern_sel = 2'd1;
        push_frame(2'd1);
        hp0 = href_pulses;
        @(negedge clk);
        check("fs_pulse", frame_start, 0);
        check("fd_pulse", frame_done, 0);
        wait_pulse("f2_done", 1'b1, 600, el);
        #1;
        check("f2_len", el + 1, 560);
        check("f2_hrefs", href_pulses - hp0, 4);
        frame_end(2);

        pattern_sel = 2'd2;
        push_frame(2'd2);
        wait_pulse("f3_done", 1'b1, 600, el);
        #1;
        frame_end(3);
        wait_pulse("f4_done", 1'b1, 600, el);
        #1;
        frame_end(4);
        sb_on = 1'b0;
        check("sb_drain", exp_q.size(), 0);

        // Asynchronous reset in the middle of an active line
        el = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (cam_href) begin
                el = i;
                break;
            end
        end
        check("f5_href_seen", 32'(el > 0), 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_quiet("arst");
        saw_fd = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (frame_done) saw_fd = 1'b1;
        end
        enable = 1'b0;
        rst_n  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (frame_done) saw_fd = 1'b1;
        end
        check("rst_no_fd", saw_fd, 0);
        check("rst_count", frame_count, 0);

        // Enable dropped 30 pclks into frame 2: frame drains, then idle
        pattern_sel = 2'd0;
        push_frame(2'd0);
        push_frame(2'd0);
        sb_on  = 1'b1;
        enable = 1'b1;
        wait_pulse("b1_start", 1'b0, 10, el);
        wait_pulse("b1_done", 1'b1, 600, el);
        #1;
        check("b1_len", el, 560);
        frame_end(1);
        pr = 0;
        pv = cam_pclk;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cam_pclk && !pv) pr++;
            pv = cam_pclk;
            if (pr == 30) break;
        end
        check("b_pclk30", pr, 30);
        enable = 1'b0;
        wait_pulse("b2_done", 1'b1, 600, el);
        #1;
        frame_end(2);
        check("b_busy", busy, 0);
        check("b_nostart", frame_start, 0);
        saw_fs   = 1'b0;
        saw_pclk = 1'b0;
        saw_busy = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (frame_start) saw_fs = 1'b1;
            if (cam_pclk) saw_pclk = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        check("b_no_fs", saw_fs, 0);
        check("b_pclk_low", saw_pclk, 0);
        check("b_idle", saw_busy, 0);
        check("b_count", frame_count, 2);
        check("sb_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
